// File: rtl/ammo_launcher_if.sv
// ammo_launcher_if: fire/ship inputs and bullet outputs of the launcher.
// slave is the launcher side, master the ship/collision side.
interface ammo_launcher_if;
  logic       fire;
  logic [9:0] ship_x;
  logic [9:0] ship_y;
  logic       bullet_hit;
  logic [9:0] ball_ammo_x;
  logic [9:0] ball_ammo_y;
  logic [9:0] ball_ammo_size;
  logic       ammo_active;
  logic       cooldown_busy;
  logic [7:0] shot_count;
  logic [3:0] ammo_left;

  modport master (
    output fire, ship_x, ship_y, bullet_hit,
    input  ball_ammo_x, ball_ammo_y, ball_ammo_size,
    input  ammo_active, cooldown_busy, shot_count, ammo_left
  );

  modport slave (
    input  fire, ship_x, ship_y, bullet_hit,
    output ball_ammo_x, ball_ammo_y, ball_ammo_size,
    output ammo_active, cooldown_busy, shot_count, ammo_left
  );
endinterface

// File: rtl/ammo_launcher.sv
// ammo_launcher: single-bullet launcher with retire cooldown.
// Define AMMO_LIMIT_EN for a finite magazine with a RELOAD state.
module ammo_launcher #(
  parameter int AMMO_SIZE       = 4,
  parameter int AMMO_SPEED      = 6,
  parameter int Y_TOP           = 3,
  parameter int PARK_X          = 700,
  parameter int PARK_Y          = 0,
  parameter int COOLDOWN_FRAMES = 8
`ifdef AMMO_LIMIT_EN
  ,
  parameter int MAG_SIZE        = 5,
  parameter int RELOAD_FRAMES   = 60
`endif
) (
  input  logic           Reset,
  input  logic           frame_clk,
  ammo_launcher_if.slave bus
);

  localparam logic [9:0]  SIZE_W     = 10'(AMMO_SIZE);
  localparam logic [9:0]  SPEED_W    = 10'(AMMO_SPEED);
  localparam logic [9:0]  LAUNCH_MIN = 10'(Y_TOP + AMMO_SIZE);
  localparam logic [9:0]  EXIT_MIN   = 10'(Y_TOP + AMMO_SPEED);
  localparam logic [9:0]  PARK_X_W   = 10'(PARK_X);
  localparam logic [9:0]  PARK_Y_W   = 10'(PARK_Y);
  localparam logic [15:0] CD_LOAD    = 16'(COOLDOWN_FRAMES - 1);

`ifdef AMMO_LIMIT_EN
  localparam logic [3:0]  MAG_LOAD   = 4'(MAG_SIZE);
  localparam logic [15:0] RL_LOAD    = 16'(RELOAD_FRAMES - 1);
  typedef enum logic [1:0] {
    IDLE, FLYING, COOLDOWN, RELOAD
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, FLYING, COOLDOWN
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        active_q, active_d;
  logic        busy_q, busy_d;
  logic [7:0]  shots_q, shots_d;
  logic [15:0] cnt_q, cnt_d;
  logic        fire_prev_q, fire_prev_d;
  logic        fire_rise;
  logic        can_fire;
  logic        retire;
`ifdef AMMO_LIMIT_EN
  logic [3:0]  ammo_q, ammo_d;
  assign can_fire = (ammo_q != 4'd0);
`else
  assign can_fire = 1'b1;
`endif

  assign fire_rise = bus.fire & ~fire_prev_q;
  // Compare before subtracting so the bullet never wraps past zero
  assign retire = bus.bullet_hit || (y_q < EXIT_MIN);

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    active_d    = active_q;
    busy_d      = busy_q;
    shots_d     = shots_q;
    cnt_d       = cnt_q;
    fire_prev_d = bus.fire;
`ifdef AMMO_LIMIT_EN
    ammo_d      = ammo_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (fire_rise && can_fire &&
            bus.ship_y >= LAUNCH_MIN) begin
          state_d  = FLYING;
          x_d      = bus.ship_x;
          y_d      = bus.ship_y - SIZE_W;
          active_d = 1'b1;
          if (shots_q != 8'hFF)
            shots_d = shots_q + 8'd1;
`ifdef AMMO_LIMIT_EN
          ammo_d = ammo_q - 4'd1;
`endif
        end
      end
      FLYING: begin
        if (retire) begin
          x_d      = PARK_X_W;
          y_d      = PARK_Y_W;
          active_d = 1'b0;
          busy_d   = 1'b1;
          state_d  = COOLDOWN;
          cnt_d    = CD_LOAD;
`ifdef AMMO_LIMIT_EN
          if (ammo_q == 4'd0) begin
            state_d = RELOAD;
            cnt_d   = RL_LOAD;
          end
`endif
        end else begin
          y_d = y_q - SPEED_W;
        end
      end
      COOLDOWN: begin
        if (cnt_q == 16'd0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
`ifdef AMMO_LIMIT_EN
      RELOAD: begin
        if (cnt_q == 16'd0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          ammo_d  = MAG_LOAD;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      x_q         <= PARK_X_W;
      y_q         <= PARK_Y_W;
      active_q    <= 1'b0;
      busy_q      <= 1'b0;
      shots_q     <= 8'd0;
      cnt_q       <= 16'd0;
      fire_prev_q <= 1'b1;
`ifdef AMMO_LIMIT_EN
      ammo_q      <= MAG_LOAD;
`endif
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      active_q    <= active_d;
      busy_q      <= busy_d;
      shots_q     <= shots_d;
      cnt_q       <= cnt_d;
      fire_prev_q <= fire_prev_d;
`ifdef AMMO_LIMIT_EN
      ammo_q      <= ammo_d;
`endif
    end
  end

  assign bus.ball_ammo_x    = x_q;
  assign bus.ball_ammo_y    = y_q;
  assign bus.ball_ammo_size = SIZE_W;
  assign bus.ammo_active    = active_q;
  assign bus.cooldown_busy  = busy_q;
  assign bus.shot_count     = shots_q;
`ifdef AMMO_LIMIT_EN
  assign bus.ammo_left      = ammo_q;
`else
  assign bus.ammo_left      = 4'hF;
`endif

endmodule

// File: tb/tb_ammo_launcher.sv
// tb_ammo_launcher: directed vector table plus multi-frame sequences
// for launch, flight, hit, cooldown, reset and saturation.
module tb_ammo_launcher;
  logic frame_clk = 1'b0;
  logic Reset;

  ammo_launcher_if bus ();

  ammo_launcher dut (
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .bus       (bus)
  );

  always #5 frame_clk = ~frame_clk;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic       fire;
    logic [9:0] sx;
    logic [9:0] sy;
    logic       hit;
    logic       act;
    logic [9:0] x;
    logic [9:0] y;
    logic       busy;
    logic [7:0] shots;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic add(input logic f, input int sx, input int sy,
                     input logic h, input logic a, input int x,
                     input int y, input logic b, input int s);
    vec_t v;
    v.fire = f; v.sx = 10'(sx); v.sy = 10'(sy); v.hit = h;
    v.act = a; v.x = 10'(x); v.y = 10'(y); v.busy = b;
    v.shots = 8'(s);
    vt.push_back(v);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bus.cooldown_busy || bus.ammo_active) && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    int ey;
    int nfly;
    int nbusy;
    Reset = 1'b1;
    bus.fire = 1'b1;
    bus.ship_x = 10'd300;
    bus.ship_y = 10'd400;
    bus.bullet_hit = 1'b0;
    #12;
    chk("rst_x", bus.ball_ammo_x, 700);
    chk("rst_y", bus.ball_ammo_y, 0);
    chk("rst_active", bus.ammo_active, 0);
    chk("rst_busy", bus.cooldown_busy, 0);
    chk("rst_shots", bus.shot_count, 0);
    chk("size", bus.ball_ammo_size, 4);
`ifdef AMMO_LIMIT_EN
    chk("rst_ammo_left", bus.ammo_left, 5);
`else
    chk("ammo_left_tied", bus.ammo_left, 15);
`endif
    Reset = 1'b0;

    //   fire sx   sy   hit act x    y    busy shots
    add(1, 300, 400, 0, 0, 700, 0,   0, 0);  // held through reset
    add(0, 300, 400, 0, 0, 700, 0,   0, 0);
    add(1, 300, 400, 0, 1, 300, 396, 0, 1);  // launch
    add(1, 100, 400, 0, 1, 300, 390, 0, 1);  // held, x stays
    add(0, 100, 400, 0, 1, 300, 384, 0, 1);
    add(0, 100, 400, 1, 0, 700, 0,   1, 1);  // hit -> park
    add(1, 100, 400, 0, 0, 700, 0,   1, 1);  // rise discarded
    add(0, 100, 400, 0, 0, 700, 0,   1, 1);
    add(0, 100, 400, 0, 0, 700, 0,   1, 1);
    add(0, 100, 400, 0, 0, 700, 0,   1, 1);
    add(0, 100, 400, 0, 0, 700, 0,   1, 1);
    add(0, 100, 400, 0, 0, 700, 0,   1, 1);
    add(0, 100, 400, 0, 0, 700, 0,   1, 1);  // 8th busy frame
    add(0, 100, 400, 1, 0, 700, 0,   0, 1);  // idle, hit ignored
    add(1, 300, 5,   0, 0, 700, 0,   0, 1);  // too low
    add(0, 300, 6,   0, 0, 700, 0,   0, 1);
    add(1, 300, 6,   0, 0, 700, 0,   0, 1);  // still too low
    add(0, 300, 6,   0, 0, 700, 0,   0, 1);
    add(1, 50,  7,   0, 1, 50,  3,   0, 2);  // lowest legal launch
    add(0, 50,  7,   0, 0, 700, 0,   1, 2);  // top exit, no wrap

    for (int i = 0; i < vt.size(); i++) begin
      bus.fire = vt[i].fire;
      bus.ship_x = vt[i].sx;
      bus.ship_y = vt[i].sy;
      bus.bullet_hit = vt[i].hit;
      step();
      chk($sformatf("v%0d_active", i), bus.ammo_active, vt[i].act);
      chk($sformatf("v%0d_x", i), bus.ball_ammo_x, vt[i].x);
      chk($sformatf("v%0d_y", i), bus.ball_ammo_y, vt[i].y);
      chk($sformatf("v%0d_busy", i), bus.cooldown_busy, vt[i].busy);
      chk($sformatf("v%0d_shots", i), bus.shot_count, vt[i].shots);
    end
    bus.bullet_hit = 1'b0;
    wait_idle();

    // free flight to the top and full cooldown length
    bus.fire = 1'b0;
    bus.ship_x = 10'd300;
    bus.ship_y = 10'd400;
    step();
    bus.fire = 1'b1;
    step();
    chk("ff_launch_y", bus.ball_ammo_y, 396);
    ey = 396;
    nfly = 1;
    while (bus.ammo_active && nfly < 100) begin
      step();
      if (ey < 9) begin
        chk("ff_park_x", bus.ball_ammo_x, 700);
        chk("ff_park_y", bus.ball_ammo_y, 0);
      end else begin
        ey = ey - 6;
        nfly++;
        chk("ff_y", bus.ball_ammo_y, ey);
        chk("ff_x", bus.ball_ammo_x, 300);
      end
    end
    chk("ff_frames", nfly, 66);
    chk("ff_active_off", bus.ammo_active, 0);
    nbusy = 0;
    while (bus.cooldown_busy && nbusy < 20) begin
      nbusy++;
      step();
    end
    chk("cooldown_len", nbusy, 8);

    // reset asserted mid-flight at y=200
    bus.fire = 1'b0;
    bus.ship_x = 10'd123;
    bus.ship_y = 10'd402;
    step();
    bus.fire = 1'b1;
    step();
    chk("mf_launch_y", bus.ball_ammo_y, 398);
    for (int k = 0; k < 33; k++) step();
    chk("mf_y200", bus.ball_ammo_y, 200);
    chk("mf_shots", bus.shot_count, 4);
    #2;
    Reset = 1'b1;
    #1;
    chk("mf_rst_x", bus.ball_ammo_x, 700);
    chk("mf_rst_y", bus.ball_ammo_y, 0);
    chk("mf_rst_active", bus.ammo_active, 0);
    chk("mf_rst_shots", bus.shot_count, 0);
    #3;
    Reset = 1'b0;
    step();
    chk("mf_held_no_fire", bus.ammo_active, 0);

`ifdef AMMO_LIMIT_EN
    bus.ship_y = 10'd7;
    for (int i = 0; i < 5; i++) begin
      bus.fire = 1'b0;
      step();
      bus.fire = 1'b1;
      step();
      chk("mag_launch", bus.ammo_active, 1);
      chk("mag_left", bus.ammo_left, 4 - i);
      bus.fire = 1'b0;
      step();
      nbusy = 0;
      while (bus.cooldown_busy && nbusy < 100) begin
        nbusy++;
        step();
      end
      chk("mag_busy_len", nbusy, (i == 4) ? 60 : 8);
    end
    chk("mag_reloaded", bus.ammo_left, 5);
`else
    bus.ship_y = 10'd7;
    for (int i = 0; i < 260; i++) begin
      bus.fire = 1'b0;
      step();
      bus.fire = 1'b1;
      step();
      bus.fire = 1'b0;
      step();
      wait_idle();
      if (i == 254) chk("shots_255", bus.shot_count, 255);
    end
    chk("shots_saturated", bus.shot_count, 255);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ammo_launcher.md
Name: ammo_launcher

Overview:
- Upstream producer of the bullet position consumed by the meteorite/obstacle collision stage.
- Turns the player fire key into a single bullet launched from the ship and moved up one step per frame_clk.
- Retires the bullet on the collision stage's bullet_hit or when it leaves the top of the screen, then enforces a cooldown before the next shot.
- While no bullet is in flight, parks the bullet coordinates off-screen so the collision stage cannot register hits.

Parameters:
AMMO_SIZE, 4, bullet size in pixels; driven unchanged on ball_ammo_size
AMMO_SPEED, 6, pixels the bullet moves up per frame
Y_TOP, 3, topmost legal bullet Y
PARK_X, 700, X coordinate while no bullet is in flight (off-screen)
PARK_Y, 0, Y coordinate while no bullet is in flight
COOLDOWN_FRAMES, 8, frames spent in COOLDOWN after a bullet retires; must be >= 1
MAG_SIZE, 5, magazine capacity (AMMO_LIMIT_EN only)
RELOAD_FRAMES, 60, reload duration in frames (AMMO_LIMIT_EN only)

Ports:
Reset  in  1  asynchronous, active-high reset
frame_clk  in  1  frame-rate clock; all state updates on its rising edge
fire  in  1  fire key level, sampled each frame
ship_x  in  10  ship centre X
ship_y  in  10  ship top Y
bullet_hit  in  1  registered hit flag from the collision stage
ball_ammo_x  out  10  bullet X (registered)
ball_ammo_y  out  10  bullet Y (registered)
ball_ammo_size  out  10  constant AMMO_SIZE
ammo_active  out  1  bullet is in flight
cooldown_busy  out  1  high while in COOLDOWN or RELOAD
shot_count  out  8  number of launches, saturates at 255
ammo_left  out  4  rounds remaining; constant 4'hF when AMMO_LIMIT_EN is undefined

Behaviour:
- Reset is asynchronous and active-high; clock is frame_clk.
- Reset values:
  - state=IDLE, ball_ammo_x=PARK_X, ball_ammo_y=PARK_Y.
  - ammo_active=0, cooldown_busy=0, shot_count=0, cooldown counter=0.
  - fire_prev=1, so a key already held at reset release does not fire.
  - ammo_left=MAG_SIZE.
- Reset asserted mid-flight: the bullet is parked immediately and the block returns to IDLE.
- Edge detect: fire_rise = fire & ~fire_prev; fire_prev <= fire every frame. Holding the key fires exactly one shot.
- State IDLE:
  - On fire_rise with ship_y >= Y_TOP+AMMO_SIZE: go to FLYING next frame.
    - ball_ammo_x <= ship_x, ball_ammo_y <= ship_y-AMMO_SIZE, ammo_active <= 1.
    - shot_count += 1, saturating at 255.
  - On fire_rise with ship_y < Y_TOP+AMMO_SIZE: no launch and no count change.
- State FLYING, evaluated in priority order:
  1. bullet_hit=1: park coordinates, ammo_active <= 0, go to COOLDOWN.
  2. Else if ball_ammo_y < Y_TOP+AMMO_SPEED: park, ammo_active <= 0, go to COOLDOWN (top exit). No unsigned wrap is allowed.
  3. Else: ball_ammo_y <= ball_ammo_y-AMMO_SPEED. X is held at the launch value and does not follow the ship.
- bullet_hit in IDLE or COOLDOWN is ignored.
- bullet_hit and the top-exit condition in the same frame count as a hit; the resulting state is the same either way.
- State COOLDOWN:
  - Counter is loaded with COOLDOWN_FRAMES-1 on entry; cooldown_busy=1.
  - Decrements each frame; at 0 the block goes to IDLE.
  - COOLDOWN lasts exactly COOLDOWN_FRAMES frames.
  - fire_rise during COOLDOWN is discarded, not queued.
- Latency: launch edge to first ammo_active=1 is 1 frame. Hit frame to park is 1 frame.
- Width rules: all coordinate arithmetic is 10-bit unsigned, with comparisons done before subtraction.

Optional Feature:
AMMO_LIMIT_EN:
- Defined:
  - Each launch decrements ammo_left.
  - When a bullet retires with ammo_left=0, the block goes to RELOAD instead of COOLDOWN.
  - RELOAD lasts RELOAD_FRAMES frames with cooldown_busy=1, then sets ammo_left=MAG_SIZE and goes to IDLE.
  - fire_rise in IDLE with ammo_left=0 is impossible by construction; fire_rise during RELOAD is discarded.
- Undefined: no RELOAD state exists, ammo_left is tied to 4'hF, and the magazine is unlimited.

Test Plan:
- Reset release with fire held at 1 -> no launch. Then fire 0→1 with ship_x=300, ship_y=400 -> next frame ammo_active=1, x=300, y=396, shot_count=1.
- Free flight from y=396 -> y=390, 384, … until y<9. Then x=700, y=0, ammo_active=0, cooldown_busy=1 for 8 frames, then IDLE.
- bullet_hit pulse on the 3rd frame of flight -> park next frame, COOLDOWN entered. A second fire_rise inside the cooldown produces no launch.
- Assert Reset mid-flight at y=200 -> outputs immediately x=700, y=0, active=0, shot_count=0.
- Launch with ship_y=5 -> no launch. Launch with ship_y=7 (y=3) -> retires on the next frame with no Y underflow.
- AMMO_LIMIT_EN: 5 shots -> ammo_left counts down to 0. After the 5th retires, cooldown_busy=1 for 60 frames, then ammo_left=5.
